// File: rtl/sprite_engine.sv
// sprite_engine: multi-channel sprite compositor for a raster video pipe.
// Each pixel is tested against NUM_SPR sprite rectangles; the lowest-index hit
// selects a ROM address, the ROM's colour index is looked up in a two-bank
// palette, and the resulting colour appears a fixed three clock edges later.
//
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   pix_valid, DrawX/DrawY  current raster pixel and its valid strobe
//   frame_start             one-cycle pulse per video frame (animation timing)
//   StartX/StartY           packed per-sprite top-left corners (10 bits each)
//   spr_en/alt_color/anim_en per-sprite enable, palette bank, animation enable
//   pal_we/pal_addr/pal_data palette write port ({bank, index} addressing)
//   rom_addr / rom_data     external sprite ROM, data one cycle after address
//   Red/Green/Blue, show    composited pixel colour and visibility
//   hit_id                  winning sprite channel (0 when not shown)
module sprite_engine #(
    parameter int unsigned NUM_SPR    = 4,
    parameter int unsigned SPR_W      = 108,
    parameter int unsigned SPR_H      = 108,
    parameter int unsigned FRAMES     = 4,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned TRANSP_IDX = 7,
    parameter int unsigned ANIM_DIV   = 15,
    parameter int unsigned ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       pix_valid,
    input  logic                       frame_start,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic [NUM_SPR*10-1:0]      StartX,
    input  logic [NUM_SPR*10-1:0]      StartY,
    input  logic [NUM_SPR-1:0]         spr_en,
    input  logic [NUM_SPR-1:0]         alt_color,
    input  logic [NUM_SPR-1:0]         anim_en,
    input  logic                       pal_we,
    input  logic [IDX_W:0]             pal_addr,
    input  logic [11:0]                pal_data,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [IDX_W-1:0]           rom_data,
    output logic [3:0]                 Red,
    output logic [3:0]                 Green,
    output logic [3:0]                 Blue,
    output logic                       show,
    output logic [$clog2(NUM_SPR)-1:0] hit_id
);

    localparam int unsigned ID_W     = $clog2(NUM_SPR);
    localparam int unsigned FRM_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned TICK_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned PAL_N    = 2 ** (IDX_W + 1);
    localparam int unsigned FRAME_SZ = SPR_W * SPR_H;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [FRM_W-1:0]  frame_q, frame_d;

    logic              s1_valid_q, s1_hit_q, s1_alt_q;
    logic [ID_W-1:0]   s1_id_q;
    logic              s2_valid_q, s2_hit_q, s2_alt_q;
    logic [ID_W-1:0]   s2_id_q;

    logic              show_q, show_d;
    logic [11:0]       rgb_q, rgb_d;
    logic [ID_W-1:0]   hit_id_q, hit_id_d;

    logic [11:0]       pal_q [PAL_N];

    // ------------------------------------------------------------------
    // Per-channel rectangle test; 11-bit sums so StartX+SPR_W-1 never wraps
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0] hit_vec;
    logic [10:0]        sx11, sy11;
    logic [10:0]        px11, py11;

    always_comb begin
        hit_vec = '0;
        sx11    = '0;
        sy11    = '0;
        px11    = {1'b0, DrawX};
        py11    = {1'b0, DrawY};
        for (int i = 0; i < int'(NUM_SPR); i++) begin
            sx11       = {1'b0, StartX[10*i +: 10]};
            sy11       = {1'b0, StartY[10*i +: 10]};
            hit_vec[i] = spr_en[i]
                       && (px11 >= sx11) && (px11 <= sx11 + 11'(SPR_W - 1))
                       && (py11 >= sy11) && (py11 <= sy11 + 11'(SPR_H - 1));
        end
    end

    // ------------------------------------------------------------------
    // Fixed priority: scanning downwards leaves the lowest hitting index
    // ------------------------------------------------------------------
    logic            win_hit, win_alt, win_anim;
    logic [ID_W-1:0] win_id;
    logic [9:0]      win_sx, win_sy;

    always_comb begin
        win_hit  = 1'b0;
        win_alt  = 1'b0;
        win_anim = 1'b0;
        win_id   = '0;
        win_sx   = '0;
        win_sy   = '0;
        for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_hit  = 1'b1;
                win_alt  = alt_color[i];
                win_anim = anim_en[i];
                win_id   = ID_W'(i);
                win_sx   = StartX[10*i +: 10];
                win_sy   = StartY[10*i +: 10];
            end
        end
    end

    // ------------------------------------------------------------------
    // ROM address: frame base + row-major offset inside the sprite.
    // The address only moves for a valid hitting pixel.
    // ------------------------------------------------------------------
    logic [9:0]       off_x, off_y;
    logic [FRM_W-1:0] frame_sel;

    always_comb begin
        off_x      = DrawX - win_sx;
        off_y      = DrawY - win_sy;
        frame_sel  = win_anim ? frame_q : '0;
        rom_addr_d = rom_addr_q;
        if (pix_valid && win_hit) begin
            rom_addr_d = ADDR_W'(frame_sel) * ADDR_W'(FRAME_SZ)
                       + ADDR_W'(SPR_W) * ADDR_W'(off_y)
                       + ADDR_W'(off_x);
        end
    end

    // ------------------------------------------------------------------
    // Animation: ANIM_DIV frame_start pulses per step, FRAMES steps per loop
    // ------------------------------------------------------------------
    always_comb begin
        tick_d  = tick_q;
        frame_d = frame_q;
        if (frame_start) begin
            if (tick_q == TICK_W'(ANIM_DIV - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FRM_W'(FRAMES - 1)) ? '0 : frame_q + FRM_W'(1);
            end else begin
                tick_d  = tick_q + TICK_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: rom_data now belongs to the stage-2 pixel.
    // A transparent winner blanks the pixel; no fall-through.
    // ------------------------------------------------------------------
    logic [11:0] pal_rd;
    logic        vis;

    always_comb begin
        pal_rd   = pal_q[{s2_alt_q, rom_data}];
        vis      = s2_valid_q && s2_hit_q && (rom_data != IDX_W'(TRANSP_IDX));
        show_d   = vis;
        rgb_d    = vis ? pal_rd : 12'h000;
        hit_id_d = vis ? s2_id_q : '0;
    end

    // Address and animation state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            tick_q     <= '0;
            frame_q    <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            tick_q     <= tick_d;
            frame_q    <= frame_d;
        end
    end

    // Pixel metadata travelling beside the ROM access
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_alt_q   <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_alt_q   <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            s1_valid_q <= pix_valid;
            s1_hit_q   <= win_hit;
            s1_alt_q   <= win_alt;
            s1_id_q    <= win_id;
            s2_valid_q <= s1_valid_q;
            s2_hit_q   <= s1_hit_q;
            s2_alt_q   <= s1_alt_q;
            s2_id_q    <= s1_id_q;
        end
    end

    // Registered pixel outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            show_q   <= 1'b0;
            rgb_q    <= 12'h000;
            hit_id_q <= '0;
        end else begin
            show_q   <= show_d;
            rgb_q    <= rgb_d;
            hit_id_q <= hit_id_d;
        end
    end

    // Palette: write lands on the edge, so a same-edge read sees the old entry
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < int'(PAL_N); k++) begin
                pal_q[k] <= 12'h000;
            end
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    assign rom_addr = rom_addr_q;
    assign Red      = rgb_q[11:8];
    assign Green    = rgb_q[7:4];
    assign Blue     = rgb_q[3:0];
    assign show     = show_q;
    assign hit_id   = hit_id_q;

endmodule
